pca_register_bank: RTL and testbench

- Register file directly downstream of i2c_target: consumes the target's received-byte and read-request strobes and implements the PCA9685-compatible register map.
- Holds MODE1/MODE2, sub/all-call addresses, 16 LED ON/OFF channel registers, ALL_LED broadcast and PRE_SCALE.
- Drives the configuration buses read by the PWM engine.
- Owns the register pointer and auto-increment logic so i2c_target stays byte-level only.

---
 rtl/pca_regs_pkg.sv | 62 ++++++
 rtl/pca_led_channel_regs.sv | 54 +++++
 rtl/pca_register_bank.sv | 191 +++++++++++++++++++
 tb/tb_pca_register_bank.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/pca_regs_pkg.sv
// Register map, reset values and shared helpers for the PCA9685-style register bank.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package pca_regs_pkg;

    // Register addresses
    localparam logic [7:0] ADDR_MODE1         = 8'h00;
    localparam logic [7:0] ADDR_MODE2         = 8'h01;
    localparam logic [7:0] ADDR_SUBADR1       = 8'h02;
    localparam logic [7:0] ADDR_SUBADR2       = 8'h03;
    localparam logic [7:0] ADDR_SUBADR3       = 8'h04;
    localparam logic [7:0] ADDR_ALLCALLADR    = 8'h05;
    localparam logic [7:0] ADDR_LED0_ON_L     = 8'h06;
    localparam logic [7:0] ADDR_LED15_OFF_H   = 8'h45;
    localparam logic [7:0] ADDR_ALL_LED_ON_L  = 8'hFA;
    localparam logic [7:0] ADDR_ALL_LED_OFF_H = 8'hFD;
    localparam logic [7:0] ADDR_PRESCALE      = 8'hFE;
    localparam logic [7:0] ADDR_TESTMODE      = 8'hFF;

    // Reset values
    localparam logic [7:0] RST_PTR        = 8'h00;
    localparam logic [7:0] RST_MODE1      = 8'h11;
    localparam logic [7:0] RST_MODE2      = 8'h04;
    localparam logic [7:0] RST_SUBADR1    = 8'hE2;
    localparam logic [7:0] RST_SUBADR2    = 8'hE4;
    localparam logic [7:0] RST_SUBADR3    = 8'hE8;
    localparam logic [7:0] RST_ALLCALLADR = 8'hE0;
    localparam logic [7:0] RST_LED_ON_L   = 8'h00;
    localparam logic [4:0] RST_LED_ON_H   = 5'h00;
    localparam logic [7:0] RST_LED_OFF_L  = 8'h00;
    localparam logic [4:0] RST_LED_OFF_H  = 5'h10;
    localparam logic [7:0] RST_PRESCALE   = 8'h1E;

    // MODE1 bit positions
    localparam int MODE1_RESTART = 7;
    localparam int MODE1_AI      = 5;
    localparam int MODE1_SLEEP   = 4;

    // Transaction state encoding
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PTR  = 2'd1,
        ST_DATA = 2'd2
    } txn_state_e;

    // Auto-increment: the LED block wraps back to MODE1, as does the top of the map.
    function automatic logic [7:0] ptr_next(input logic [7:0] ptr);
        if ((ptr == ADDR_LED15_OFF_H) || (ptr == ADDR_TESTMODE)) begin
            return 8'h00;
        end
        return ptr + 8'h01;
    endfunction

    function automatic logic is_led_addr(input logic [7:0] ptr);
        return (ptr >= ADDR_LED0_ON_L) && (ptr <= ADDR_LED15_OFF_H);
    endfunction

    function automatic logic is_all_led_addr(input logic [7:0] ptr);
        return (ptr >= ADDR_ALL_LED_ON_L) && (ptr <= ADDR_ALL_LED_OFF_H);
    endfunction

endpackage

// File: rtl/pca_led_channel_regs.sv
// Four-byte ON/OFF storage for one LED channel, written individually or by ALL_LED broadcast.
// Latency: writes land on the clock edge after the enable; outputs are direct register views.
// Backpressure: none, every enabled write is accepted.
module pca_led_channel_regs
    import pca_regs_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        wr_en_i,
    input  logic [1:0]  wr_sel_i,
    input  logic        all_wr_en_i,
    input  logic [1:0]  all_sel_i,
    input  logic [7:0]  wr_data_i,
    output logic [12:0] led_on_o,
    output logic [12:0] led_off_o,
    output logic [31:0] rd_bytes_o
);

    logic [7:0] r_on_l;
    logic [4:0] r_on_h;
    logic [7:0] r_off_l;
    logic [4:0] r_off_h;

    logic [1:0] w_sel;
    logic       w_en;

    // Broadcast and individual writes never coincide; broadcast selects the byte when active.
    always_comb begin
        w_en  = wr_en_i | all_wr_en_i;
        w_sel = all_wr_en_i ? all_sel_i : wr_sel_i;
    end

    // Byte storage; the high bytes keep only bits [4:0] (full flag + count[11:8]).
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_on_l  <= RST_LED_ON_L;
            r_on_h  <= RST_LED_ON_H;
            r_off_l <= RST_LED_OFF_L;
            r_off_h <= RST_LED_OFF_H;
        end else if (w_en) begin
            case (w_sel)
                2'd0:    r_on_l  <= wr_data_i;
                2'd1:    r_on_h  <= wr_data_i[4:0];
                2'd2:    r_off_l <= wr_data_i;
                default: r_off_h <= wr_data_i[4:0];
            endcase
        end
    end

    assign led_on_o   = {r_on_h, r_on_l};
    assign led_off_o  = {r_off_h, r_off_l};
    assign rd_bytes_o = {3'b000, r_off_h, r_off_l, 3'b000, r_on_h, r_on_l};

endmodule

// File: rtl/pca_register_bank.sv
// PCA9685-compatible register file behind the byte-level I2C target: pointer, auto-increment, config buses.
// Latency: writes update registers and pulse reg_update_o one edge after wr_valid_i; reads return one cycle after rd_req_i.
// Backpressure: none; strobes are accepted every cycle, lower-priority strobes in a busy cycle are dropped.
module pca_register_bank
    import pca_regs_pkg::*;
#(
    parameter int         NUM_CH       = 16,
    parameter logic [7:0] PRESCALE_MIN = 8'h03
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  txn_start_i,
    input  logic                  txn_stop_i,
    input  logic                  wr_valid_i,
    input  logic [7:0]            wr_data_i,
    input  logic                  rd_req_i,
    output logic [7:0]            rd_data_o,
    output logic                  rd_valid_o,
    output logic [7:0]            mode1_o,
    output logic [7:0]            mode2_o,
    output logic [7:0]            prescale_o,
    output logic [NUM_CH*13-1:0]  led_on_o,
    output logic [NUM_CH*13-1:0]  led_off_o,
    output logic                  reg_update_o
);

    txn_state_e r_state;
    logic [7:0] r_ptr;
    logic [7:0] r_rd_data;
    logic       r_rd_valid;

    logic [7:0] r_mode1;
    logic [7:0] r_mode2;
    logic [7:0] r_subadr1;
    logic [7:0] r_subadr2;
    logic [7:0] r_subadr3;
    logic [7:0] r_allcall;
    logic [7:0] r_prescale;
    logic       r_reg_update;

    logic        w_data_wr;
    logic        w_is_led;
    logic        w_is_all;
    logic [5:0]  w_led_off;
    logic [3:0]  w_ch_idx;
    logic [1:0]  w_ch_sel;
    logic [1:0]  w_all_sel;
    logic        w_all_wr;
    logic        w_prescale_ok;
    logic        w_commit;
    logic [7:0]  w_ptr_adv;
    logic [7:0]  w_rd_byte;
    logic [31:0] w_ch_bytes [NUM_CH];

    // Decode of the current pointer and of an accepted data-phase write.
    always_comb begin
        w_data_wr     = wr_valid_i & ~txn_start_i & ~txn_stop_i & (r_state == ST_DATA);
        w_is_led      = is_led_addr(r_ptr);
        w_is_all      = is_all_led_addr(r_ptr);
        w_led_off     = r_ptr[5:0] - ADDR_LED0_ON_L[5:0];
        w_ch_idx      = w_led_off[5:2];
        w_ch_sel      = w_led_off[1:0];
        // 0xFA..0xFD have low bits 2,3,0,1; subtracting 2 maps them to ON_L..OFF_H.
        w_all_sel     = r_ptr[1:0] - 2'd2;
        w_all_wr      = w_data_wr & w_is_all;
        w_prescale_ok = w_data_wr & (r_ptr == ADDR_PRESCALE) & r_mode1[MODE1_SLEEP];
        // Addresses 0x00..0x45 are all backed by storage.
        w_commit      = (w_data_wr & (r_ptr <= ADDR_LED15_OFF_H)) | w_all_wr | w_prescale_ok;
        // AI is sampled before any MODE1 write in the same cycle takes effect.
        w_ptr_adv     = r_mode1[MODE1_AI] ? ptr_next(r_ptr) : r_ptr;
    end

    // Read mux: unmapped addresses, ALL_LED and TESTMODE all read as zero.
    always_comb begin
        w_rd_byte = 8'h00;
        if (w_is_led) begin
            w_rd_byte = w_ch_bytes[w_ch_idx][8*w_ch_sel +: 8];
        end else begin
            case (r_ptr)
                ADDR_MODE1:      w_rd_byte = r_mode1;
                ADDR_MODE2:      w_rd_byte = r_mode2;
                ADDR_SUBADR1:    w_rd_byte = r_subadr1;
                ADDR_SUBADR2:    w_rd_byte = r_subadr2;
                ADDR_SUBADR3:    w_rd_byte = r_subadr3;
                ADDR_ALLCALLADR: w_rd_byte = r_allcall;
                ADDR_PRESCALE:   w_rd_byte = r_prescale;
                default:         w_rd_byte = 8'h00;
            endcase
        end
    end

    // Transaction FSM: owns state, pointer and the registered read response.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= ST_IDLE;
            r_ptr      <= RST_PTR;
            r_rd_data  <= 8'h00;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= 1'b0;
            if (txn_start_i) begin
                r_state <= ST_PTR;
            end else if (txn_stop_i) begin
                r_state <= ST_IDLE;
            end else begin
                case (r_state)
                    ST_PTR: begin
                        if (wr_valid_i) begin
                            r_ptr   <= wr_data_i;
                            r_state <= ST_DATA;
                        end else if (rd_req_i) begin
                            r_rd_data  <= w_rd_byte;
                            r_rd_valid <= 1'b1;
                            r_ptr      <= w_ptr_adv;
                        end
                    end
                    ST_DATA: begin
                        if (wr_valid_i) begin
                            r_ptr <= w_ptr_adv;
                        end else if (rd_req_i) begin
                            r_rd_data  <= w_rd_byte;
                            r_rd_valid <= 1'b1;
                            r_ptr      <= w_ptr_adv;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    // Global configuration registers and the write-commit strobe.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_mode1      <= RST_MODE1;
            r_mode2      <= RST_MODE2;
            r_subadr1    <= RST_SUBADR1;
            r_subadr2    <= RST_SUBADR2;
            r_subadr3    <= RST_SUBADR3;
            r_allcall    <= RST_ALLCALLADR;
            r_prescale   <= RST_PRESCALE;
            r_reg_update <= 1'b0;
        end else begin
            r_reg_update <= w_commit;
            if (w_data_wr) begin
                case (r_ptr)
                    ADDR_MODE1:      r_mode1   <= wr_data_i;
                    ADDR_MODE2:      r_mode2   <= wr_data_i;
                    ADDR_SUBADR1:    r_subadr1 <= wr_data_i;
                    ADDR_SUBADR2:    r_subadr2 <= wr_data_i;
                    ADDR_SUBADR3:    r_subadr3 <= wr_data_i;
                    ADDR_ALLCALLADR: r_allcall <= wr_data_i;
                    default: ;
                endcase
            end
            // The prescaler may only change while the oscillator is asleep.
            if (w_prescale_ok) begin
                r_prescale <= (wr_data_i < PRESCALE_MIN) ? PRESCALE_MIN : wr_data_i;
            end
        end
    end

    // One storage block per LED channel, sharing the broadcast write path.
    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        logic w_ch_wr;
        assign w_ch_wr = w_data_wr & w_is_led & (w_ch_idx == 4'(ch));

        pca_led_channel_regs u_ch (
            .clk_i       (clk_i),
            .rst_ni      (rst_ni),
            .wr_en_i     (w_ch_wr),
            .wr_sel_i    (w_ch_sel),
            .all_wr_en_i (w_all_wr),
            .all_sel_i   (w_all_sel),
            .wr_data_i   (wr_data_i),
            .led_on_o    (led_on_o[13*ch +: 13]),
            .led_off_o   (led_off_o[13*ch +: 13]),
            .rd_bytes_o  (w_ch_bytes[ch])
        );
    end

    assign rd_data_o    = r_rd_data;
    assign rd_valid_o   = r_rd_valid;
    assign mode1_o      = r_mode1;
    assign mode2_o      = r_mode2;
    assign prescale_o   = r_prescale;
    assign reg_update_o = r_reg_update;

endmodule

// File: tb/tb_pca_register_bank.sv
// Directed bench for pca_register_bank: read responses checked by a scoreboard monitor, buses checked inline.
// Latency: n/a.
// Backpressure: n/a.
module tb_pca_register_bank;

    logic         clk;
    logic         rst_n;
    logic         txn_start;
    logic         txn_stop;
    logic         wr_valid;
    logic [7:0]   wr_data;
    logic         rd_req;
    logic [7:0]   rd_data;
    logic         rd_valid;
    logic [7:0]   mode1;
    logic [7:0]   mode2;
    logic [7:0]   prescale;
    logic [207:0] led_on;
    logic [207:0] led_off;
    logic         reg_update;

    int checks = 0;
    int errors = 0;
    int upd_cnt = 0;
    logic [7:0] exp_q [$];
    string      name_q [$];

    pca_register_bank #(.NUM_CH(16), .PRESCALE_MIN(8'h03)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .txn_start_i  (txn_start),
        .txn_stop_i   (txn_stop),
        .wr_valid_i   (wr_valid),
        .wr_data_i    (wr_data),
        .rd_req_i     (rd_req),
        .rd_data_o    (rd_data),
        .rd_valid_o   (rd_valid),
        .mode1_o      (mode1),
        .mode2_o      (mode2),
        .prescale_o   (prescale),
        .led_on_o     (led_on),
        .led_off_o    (led_off),
        .reg_update_o (reg_update)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every read response pops one expected byte.
    always @(negedge clk) begin
        if (rst_n) begin
            if (reg_update) upd_cnt++;
            if (rd_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_read: got 0x%0h, expected no response", rd_data);
                end else begin
                    check(name_q.pop_front(), {24'h0, rd_data}, {24'h0, exp_q.pop_front()});
                end
            end
        end
    end

    task automatic pulse_start();
        @(negedge clk); txn_start = 1'b1;
        @(negedge clk); txn_start = 1'b0;
    endtask

    task automatic pulse_stop();
        @(negedge clk); txn_stop = 1'b1;
        @(negedge clk); txn_stop = 1'b0;
    endtask

    task automatic wr_byte(input logic [7:0] b);
        @(negedge clk); wr_valid = 1'b1; wr_data = b;
        @(negedge clk); wr_valid = 1'b0;
    endtask

    task automatic rd_exp(input string name, input logic [7:0] exp);
        exp_q.push_back(exp);
        name_q.push_back(name);
        @(negedge clk); rd_req = 1'b1;
        @(negedge clk); rd_req = 1'b0;
    endtask

    task automatic write_reg(input logic [7:0] a, input logic [7:0] d);
        pulse_start(); wr_byte(a); wr_byte(d); pulse_stop();
    endtask

    task automatic read_at(input string name, input logic [7:0] a, input logic [7:0] exp);
        pulse_start(); wr_byte(a); rd_exp(name, exp); pulse_stop();
    endtask

    // Bounded wait for all outstanding read responses.
    task automatic drain(input string name);
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        check(name, exp_q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int u0;
        logic [15:0] full_off_bits;
        rst_n = 1'b0; txn_start = 1'b0; txn_stop = 1'b0;
        wr_valid = 1'b0; wr_data = 8'h00; rd_req = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_mode1", mode1, 8'h11);
        check("rst_mode2", mode2, 8'h04);
        check("rst_prescale", prescale, 8'h1E);
        check("rst_rd_valid", rd_valid, 1'b0);
        check("rst_rd_data", rd_data, 8'h00);
        check("rst_reg_update", reg_update, 1'b0);
        check("rst_led0_on", led_on[12:0], 13'h0000);
        check("rst_led_off_all", (led_off == {16{13'h1000}}), 1'b1);
        rst_n = 1'b1;
        read_at("rd_rst_00", 8'h00, 8'h11);
        read_at("rd_rst_01", 8'h01, 8'h04);
        read_at("rd_rst_09", 8'h09, 8'h10);
        read_at("rd_rst_fe", 8'hFE, 8'h1E);
        drain("drain_reset");

        // Auto-increment burst into LED0
        write_reg(8'h00, 8'h31);
        u0 = upd_cnt;
        pulse_start(); wr_byte(8'h06);
        wr_byte(8'h34); wr_byte(8'h12); wr_byte(8'h78); wr_byte(8'h16);
        pulse_stop();
        // ON_H = 0x12 has bit 4 set, so full_on is raised alongside count 0x234.
        check("burst_led0_on", led_on[12:0], 13'h1234);
        check("burst_led0_off", led_off[12:0], 13'h1678);
        check("burst_updates", upd_cnt - u0, 4);
        pulse_start(); wr_byte(8'h06);
        rd_exp("burst_rd0", 8'h34); rd_exp("burst_rd1", 8'h12);
        rd_exp("burst_rd2", 8'h78); rd_exp("burst_rd3", 8'h16);
        pulse_stop();
        drain("drain_burst");

        // Wrap from LED15_OFF_H back to MODE1
        pulse_start(); wr_byte(8'h45); wr_byte(8'hAA); wr_byte(8'hBB); pulse_stop();
        check("wrap_mode1", mode1, 8'hBB);
        check("wrap_led15_off", led_off[15*13 +: 13], 13'h0A00);
        read_at("wrap_rd45", 8'h45, 8'h0A);
        drain("drain_wrap");

        // AI off: pointer holds across reads
        write_reg(8'h00, 8'h01);
        pulse_start(); wr_byte(8'h02);
        rd_exp("noai_rd0", 8'hE2); rd_exp("noai_rd1", 8'hE2); rd_exp("noai_rd2", 8'hE2);
        pulse_stop();
        drain("drain_noai");

        // ALL_LED_OFF_H broadcast clears every full_off
        write_reg(8'hFD, 8'h00);
        for (int i = 0; i < 16; i++) full_off_bits[i] = led_off[13*i + 12];
        check("bcast_full_off", full_off_bits, 16'h0000);
        check("bcast_led0_off", led_off[12:0], 13'h0078);
        read_at("bcast_rd_fd", 8'hFD, 8'h00);
        drain("drain_bcast");

        // PRE_SCALE: ignored while awake, clamped while asleep
        write_reg(8'hFE, 8'h80);
        check("ps_awake", prescale, 8'h1E);
        write_reg(8'h00, 8'h11);
        write_reg(8'hFE, 8'h01);
        check("ps_clamp", prescale, 8'h03);
        read_at("ps_rd", 8'hFE, 8'h03);
        drain("drain_ps");

        // Reserved range: write ignored, reads zero
        write_reg(8'h50, 8'hAB);
        read_at("resv_rd", 8'h50, 8'h00);
        drain("drain_resv");

        // txn_start beats wr_valid: no write, FSM back in PTR
        pulse_start(); wr_byte(8'h01);
        u0 = upd_cnt;
        @(negedge clk); txn_start = 1'b1; wr_valid = 1'b1; wr_data = 8'hFF;
        @(negedge clk); txn_start = 1'b0; wr_valid = 1'b0;
        @(negedge clk);
        check("prio_mode2", mode2, 8'h04);
        check("prio_no_update", upd_cnt - u0, 0);
        wr_byte(8'h00); wr_byte(8'h15); pulse_stop();
        check("prio_ptr_state_mode1", mode1, 8'h15);
        check("prio_ptr_state_mode2", mode2, 8'h04);

        // Reset mid-transaction
        pulse_start(); wr_byte(8'h01);
        @(negedge clk); wr_valid = 1'b1; wr_data = 8'h77; rst_n = 1'b0;
        #1;
        check("mid_rst_mode1", mode1, 8'h11);
        @(negedge clk); wr_valid = 1'b0;
        check("mid_rst_mode2", mode2, 8'h04);
        rst_n = 1'b1;
        wr_byte(8'h99);
        check("idle_wr_ignored", mode2, 8'h04);
        read_at("mid_rst_rd", 8'h00, 8'h11);
        drain("drain_final");

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
